// File: rtl/crc_net_pkg.sv
// Shared definitions for the CRC-8 receive path: frame states, CRC-8 constants
// and the single-bit CRC update used by the serial engine.
package crc_net_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CRC     = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam logic [7:0] CRC8_POLY         = 8'h07;
    localparam logic [7:0] CRC8_INIT         = 8'h00;
    localparam logic [7:0] CRC8_GOOD_RESIDUE = 8'h00;

    // One MSB-first shift of the CRC-8 register with the incoming data bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic data_bit);
        logic fb;
        fb = crc[7] ^ data_bit;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 engine (poly 0x07, no reflection). Clear has priority over
// enable; crc_next exposes the value loaded at the coming edge.
module crc8_serial
    import crc_net_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_in,
    output logic [7:0] crc_next
);

    logic [7:0] r_crc;
    logic [7:0] w_crc_next;

    // Next CRC value: clear, shift in one bit, or hold.
    always_comb begin
        w_crc_next = r_crc;
        if (clear) begin
            w_crc_next = CRC8_INIT;
        end else if (enable) begin
            w_crc_next = crc8_step(r_crc, data_in);
        end else begin
            w_crc_next = r_crc;
        end
    end

    // CRC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= CRC8_INIT;
        end else begin
            r_crc <= w_crc_next;
        end
    end

    assign crc_next = w_crc_next;

endmodule

// File: rtl/crc8_rx_frame_ctrl.sv
// Receive frame controller: parses length-prefixed serial frames, reassembles
// payload bytes and checks the trailing CRC-8 through one crc8_serial instance.
module crc8_rx_frame_ctrl
    import crc_net_pkg::*;
#(
    parameter int MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sof,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [7:0] len_out,
    output logic       busy,
    output logic       frame_done,
    output logic       crc_ok,
    output logic       crc_err,
    output logic       len_err,
    output logic       abort
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e     r_state;
    state_e     w_state_next;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_byte_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_byte_out;
    logic       r_byte_valid;
    logic [7:0] r_len;
    logic       r_busy;
    logic       r_frame_done;
    logic       r_crc_ok;
    logic       r_crc_err;
    logic       r_len_err;
    logic       r_abort;

    logic       w_busy_state;
    logic       w_busy_next;
    logic       w_crc_clear;
    logic       w_crc_enable;
    logic [7:0] w_crc_next;
    logic       w_last_bit;
    logic       w_last_payload;
    logic       w_len_ok;
    logic [7:0] w_byte_full;

    // The byte being completed includes the bit on the wire this cycle.
    assign w_byte_full    = {r_shift[6:0], bit_in};
    assign w_last_bit     = w_crc_enable && (r_bit_cnt == 3'd7);
    assign w_last_payload = ((r_byte_cnt + 8'd1) == r_len);
    assign w_len_ok       = (w_byte_full != 8'd0) && (w_byte_full <= MAX_LEN_B);

    crc8_serial u_crc (
        .clk      (clk),
        .rst_n    (~rst),
        .clear    (w_crc_clear),
        .enable   (w_crc_enable),
        .data_in  (bit_in),
        .crc_next (w_crc_next)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; sof restarts the frame from any state.
    always_comb begin
        w_state_next = r_state;
        if (sof) begin
            w_state_next = LEN;
        end else begin
            case (r_state)
                IDLE:    w_state_next = IDLE;
                LEN:     if (w_last_bit) w_state_next = w_len_ok ? PAYLOAD : IDLE;
                         else            w_state_next = LEN;
                PAYLOAD: if (w_last_bit && w_last_payload) w_state_next = CRC;
                         else                              w_state_next = PAYLOAD;
                CRC:     if (w_last_bit) w_state_next = DONE;
                         else            w_state_next = CRC;
                DONE:    w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // FSM decode: busy flags and CRC engine control.
    always_comb begin
        w_busy_state = 1'b0;
        w_busy_next  = 1'b0;
        case (r_state)
            LEN, PAYLOAD, CRC: w_busy_state = 1'b1;
            default:           w_busy_state = 1'b0;
        endcase
        case (w_state_next)
            LEN, PAYLOAD, CRC: w_busy_next = 1'b1;
            default:           w_busy_next = 1'b0;
        endcase
        w_crc_clear  = (r_state == IDLE) || (r_state == DONE) || sof;
        w_crc_enable = bit_valid && w_busy_state && !sof;
    end

    // Bit/byte counters and payload shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 8'd0;
            r_shift    <= 8'd0;
        end else if (sof) begin
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 8'd0;
            r_shift    <= 8'd0;
        end else if (w_crc_enable) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_shift   <= w_byte_full;
            if ((r_state == PAYLOAD) && (r_bit_cnt == 3'd7)) begin
                r_byte_cnt <= r_byte_cnt + 8'd1;
            end
        end
    end

    // Registered outputs: strobes, latched length and CRC verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_out   <= 8'd0;
            r_byte_valid <= 1'b0;
            r_len        <= 8'd0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_crc_ok     <= 1'b0;
            r_crc_err    <= 1'b0;
            r_len_err    <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_byte_valid <= w_last_bit && (r_state == PAYLOAD);
            if (w_last_bit && (r_state == PAYLOAD)) begin
                r_byte_out <= w_byte_full;
            end
            if (w_last_bit && (r_state == LEN)) begin
                r_len <= w_byte_full;
            end
            r_len_err    <= w_last_bit && (r_state == LEN) && !w_len_ok;
            r_frame_done <= w_last_bit && (r_state == CRC);
            r_crc_ok     <= w_last_bit && (r_state == CRC) && (w_crc_next == CRC8_GOOD_RESIDUE);
            r_crc_err    <= w_last_bit && (r_state == CRC) && (w_crc_next != CRC8_GOOD_RESIDUE);
            r_abort      <= sof && w_busy_state;
            r_busy       <= w_busy_next;
        end
    end

    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign len_out    = r_len;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign crc_ok     = r_crc_ok;
    assign crc_err    = r_crc_err;
    assign len_err    = r_len_err;
    assign abort      = r_abort;

endmodule
